// File: rtl/tl_tx_error_msg_gen.sv
// Converts RX error events into ERR_FATAL / ERR_NONFATAL message TLP headers,
// coalesced per severity and gated by posted-header flow-control credit.
module tl_tx_error_msg_gen #(
  parameter int FC_HDR_CREDS_WIDTH = 8,
  parameter int REQUESTER_ID_WIDTH = 16,
  parameter int CNT_WIDTH          = 8
) (
  input  logic                          i_clk,
  input  logic                          i_n_rst,
  input  logic                          i_error_check,
  input  logic [2:0]                    i_error_type,
  input  logic [REQUESTER_ID_WIDTH-1:0] i_device_id,
  input  logic                          i_cfg_fatal_report_en,
  input  logic                          i_cfg_nonfatal_report_en,
  input  logic [FC_HDR_CREDS_WIDTH-1:0] i_tx_p_hdr_credit_limit,
  input  logic [FC_HDR_CREDS_WIDTH-1:0] i_tx_p_hdr_credits_consumed,
  input  logic                          i_tx_p_hdr_infinite,
  input  logic                          i_msg_ready,
  output logic                          o_msg_valid,
  output logic [127:0]                  o_msg_hdr,
  output logic                          o_p_hdr_credit_consume,
  output logic                          o_fatal_status,
  output logic                          o_nonfatal_status,
  input  logic                          i_status_clr,
  output logic [CNT_WIDTH-1:0]          o_msg_sent_count
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [31:0] MSG_DW0      = 32'h3000_0000;
  localparam logic [7:0]  CODE_FATAL   = 8'h33;
  localparam logic [7:0]  CODE_NONFATAL = 8'h31;

  state_t                        state_q, state_d;
  logic                          fatal_pend_q, nf_pend_q;
  logic                          sev_fatal_q;
  logic [127:0]                  hdr_q;
  logic [CNT_WIDTH-1:0]          cnt_q;
  logic                          fatal_q, nonfatal_q;

  logic                          fatal_evt, nf_evt;
  logic                          fatal_set, nf_set;
  logic [FC_HDR_CREDS_WIDTH-1:0] avail;
  logic                          credit_ok;
  logic                          start;
  logic                          handshake;
  logic [15:0]                   req_id;

  assign fatal_evt = i_error_check && (i_error_type == 3'b001 ||
                                       i_error_type == 3'b010 ||
                                       i_error_type == 3'b011);
  assign nf_evt    = i_error_check && i_error_type[2];
  assign fatal_set = fatal_evt && i_cfg_fatal_report_en;
  assign nf_set    = nf_evt && i_cfg_nonfatal_report_en;

  // A wrapped difference with the MSB set means consumed has run past limit.
  assign avail     = i_tx_p_hdr_credit_limit - i_tx_p_hdr_credits_consumed;
  assign credit_ok = i_tx_p_hdr_infinite ||
                     ((avail != '0) && !avail[FC_HDR_CREDS_WIDTH-1]);

  assign start     = (state_q == IDLE) && (fatal_pend_q || nf_pend_q) && credit_ok;
  assign handshake = (state_q == SEND) && i_msg_ready;
  assign req_id    = 16'(i_device_id);

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start)     state_d = SEND;
      SEND: if (handshake) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    o_msg_valid            = (state_q == SEND);
    o_p_hdr_credit_consume = handshake;
  end

  // Setting has priority over the handshake clear so a same-cycle event is kept.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      fatal_pend_q <= 1'b0;
      nf_pend_q    <= 1'b0;
    end else begin
      fatal_pend_q <= (fatal_pend_q && !(handshake && sev_fatal_q)) || fatal_set;
      nf_pend_q    <= (nf_pend_q && !(handshake && !sev_fatal_q)) || nf_set;
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      sev_fatal_q <= 1'b0;
      hdr_q       <= '0;
    end else if (start) begin
      sev_fatal_q <= fatal_pend_q;
      hdr_q       <= {MSG_DW0, req_id, 8'h00,
                      fatal_pend_q ? CODE_FATAL : CODE_NONFATAL, 64'h0};
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      fatal_q    <= 1'b0;
      nonfatal_q <= 1'b0;
    end else begin
      fatal_q    <= (fatal_q && !i_status_clr) || fatal_evt;
      nonfatal_q <= (nonfatal_q && !i_status_clr) || nf_evt;
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst)                      cnt_q <= '0;
    else if (handshake && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign o_msg_hdr         = hdr_q;
  assign o_fatal_status    = fatal_q;
  assign o_nonfatal_status = nonfatal_q;
  assign o_msg_sent_count  = cnt_q;

endmodule

// File: tb/tb_tl_tx_error_msg_gen.sv
// Directed bench for tl_tx_error_msg_gen: vector table plus multi-cycle sequences.
module tb_tl_tx_error_msg_gen;

  logic         clk = 1'b0;
  logic         i_n_rst;
  logic         i_error_check;
  logic [2:0]   i_error_type;
  logic [15:0]  i_device_id;
  logic         i_cfg_fatal_report_en;
  logic         i_cfg_nonfatal_report_en;
  logic [7:0]   i_tx_p_hdr_credit_limit;
  logic [7:0]   i_tx_p_hdr_credits_consumed;
  logic         i_tx_p_hdr_infinite;
  logic         i_msg_ready;
  logic         o_msg_valid;
  logic [127:0] o_msg_hdr;
  logic         o_p_hdr_credit_consume;
  logic         o_fatal_status;
  logic         o_nonfatal_status;
  logic         i_status_clr;
  logic [7:0]   o_msg_sent_count;

  always #5 clk = ~clk;

  tl_tx_error_msg_gen #(
    .FC_HDR_CREDS_WIDTH(8),
    .REQUESTER_ID_WIDTH(16),
    .CNT_WIDTH(8)
  ) dut (
    .i_clk                      (clk),
    .i_n_rst                    (i_n_rst),
    .i_error_check              (i_error_check),
    .i_error_type               (i_error_type),
    .i_device_id                (i_device_id),
    .i_cfg_fatal_report_en      (i_cfg_fatal_report_en),
    .i_cfg_nonfatal_report_en   (i_cfg_nonfatal_report_en),
    .i_tx_p_hdr_credit_limit    (i_tx_p_hdr_credit_limit),
    .i_tx_p_hdr_credits_consumed(i_tx_p_hdr_credits_consumed),
    .i_tx_p_hdr_infinite        (i_tx_p_hdr_infinite),
    .i_msg_ready                (i_msg_ready),
    .o_msg_valid                (o_msg_valid),
    .o_msg_hdr                  (o_msg_hdr),
    .o_p_hdr_credit_consume     (o_p_hdr_credit_consume),
    .o_fatal_status             (o_fatal_status),
    .o_nonfatal_status          (o_nonfatal_status),
    .i_status_clr               (i_status_clr),
    .o_msg_sent_count           (o_msg_sent_count)
  );

  typedef struct {
    logic [2:0] etype;
    logic       fen;
    logic       nen;
    logic [7:0] lim;
    logic [7:0] cons;
    logic       inf;
    logic       exp_valid;
    logic [7:0] exp_code;
    logic       exp_fs;
    logic       exp_nfs;
  } vec_t;

  vec_t vecs [13];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_n_rst                     = 1'b0;
    i_error_check               = 1'b0;
    i_error_type                = 3'b000;
    i_device_id                 = 16'h0000;
    i_cfg_fatal_report_en       = 1'b1;
    i_cfg_nonfatal_report_en    = 1'b1;
    i_tx_p_hdr_credit_limit     = 8'h05;
    i_tx_p_hdr_credits_consumed = 8'h00;
    i_tx_p_hdr_infinite         = 1'b0;
    i_msg_ready                 = 1'b0;
    i_status_clr                = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_n_rst = 1'b1;
  endtask

  function automatic logic [127:0] exp_hdr(input logic [15:0] id, input logic [7:0] code);
    return {32'h3000_0000, id, 8'h00, code, 64'h0};
  endfunction

  task automatic strobe(input logic [2:0] t);
    i_error_check = 1'b1;
    i_error_type  = t;
    tick();
    i_error_check = 1'b0;
    i_error_type  = 3'b000;
  endtask

  initial begin
    logic [127:0] held;
    logic [7:0]   codes [4];
    int           n;

    vecs[0]  = '{3'b011, 1'b1, 1'b1, 8'h05, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0};
    vecs[1]  = '{3'b101, 1'b1, 1'b1, 8'h05, 8'h00, 1'b0, 1'b1, 8'h31, 1'b0, 1'b1};
    vecs[2]  = '{3'b000, 1'b1, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 1'b1, 1'b1, 8'h40, 8'h40, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{3'b001, 1'b1, 1'b1, 8'h41, 8'h40, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0};
    vecs[5]  = '{3'b100, 1'b1, 1'b1, 8'h00, 8'h81, 1'b0, 1'b1, 8'h31, 1'b0, 1'b1};
    vecs[6]  = '{3'b100, 1'b1, 1'b1, 8'h00, 8'h7F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{3'b100, 1'b1, 1'b1, 8'h00, 8'h7F, 1'b1, 1'b1, 8'h31, 1'b0, 1'b1};
    vecs[8]  = '{3'b010, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{3'b110, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{3'b111, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 1'b1, 8'h31, 1'b0, 1'b1};
    vecs[11] = '{3'b011, 1'b1, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[12] = '{3'b010, 1'b1, 1'b1, 8'h7F, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0};

    do_reset();
    chk("rst_valid",   {127'h0, o_msg_valid}, 128'h0);
    chk("rst_hdr",     o_msg_hdr, 128'h0);
    chk("rst_consume", {127'h0, o_p_hdr_credit_consume}, 128'h0);
    chk("rst_status",  {126'h0, o_fatal_status, o_nonfatal_status}, 128'h0);
    chk("rst_count",   {120'h0, o_msg_sent_count}, 128'h0);

    for (int i = 0; i < 13; i++) begin
      logic [15:0] id;
      do_reset();
      id                          = 16'hA5C0 + 16'(i);
      i_device_id                 = id;
      i_cfg_fatal_report_en       = vecs[i].fen;
      i_cfg_nonfatal_report_en    = vecs[i].nen;
      i_tx_p_hdr_credit_limit     = vecs[i].lim;
      i_tx_p_hdr_credits_consumed = vecs[i].cons;
      i_tx_p_hdr_infinite         = vecs[i].inf;
      strobe(vecs[i].etype);
      tick();
      chk($sformatf("v%0d_valid", i), {127'h0, o_msg_valid}, {127'h0, vecs[i].exp_valid});
      chk($sformatf("v%0d_hdr", i), o_msg_hdr,
          vecs[i].exp_valid ? exp_hdr(id, vecs[i].exp_code) : 128'h0);
      chk($sformatf("v%0d_fstat", i), {127'h0, o_fatal_status}, {127'h0, vecs[i].exp_fs});
      chk($sformatf("v%0d_nfstat", i), {127'h0, o_nonfatal_status}, {127'h0, vecs[i].exp_nfs});
      chk($sformatf("v%0d_noconsume", i), {127'h0, o_p_hdr_credit_consume}, 128'h0);
      if (vecs[i].exp_valid) begin
        i_msg_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_consume", i), {127'h0, o_p_hdr_credit_consume}, 128'h1);
        tick();
        i_msg_ready = 1'b0;
        chk($sformatf("v%0d_valid_after", i), {127'h0, o_msg_valid}, 128'h0);
        chk($sformatf("v%0d_count", i), {120'h0, o_msg_sent_count}, 128'h1);
      end else begin
        repeat (3) tick();
        chk($sformatf("v%0d_still_idle", i), {127'h0, o_msg_valid}, 128'h0);
        chk($sformatf("v%0d_count", i), {120'h0, o_msg_sent_count}, 128'h0);
      end
    end

    // Header held under backpressure, immune to id/credit/enable changes
    do_reset();
    i_device_id = 16'hBEEF;
    strobe(3'b101);
    tick();
    held = exp_hdr(16'hBEEF, 8'h31);
    chk("hold_hdr0", o_msg_hdr, held);
    i_device_id                 = 16'h1234;
    i_tx_p_hdr_credit_limit     = 8'h00;
    i_cfg_nonfatal_report_en    = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold_valid%0d", k), {127'h0, o_msg_valid}, 128'h1);
      chk($sformatf("hold_hdr%0d", k), o_msg_hdr, held);
      chk($sformatf("hold_noconsume%0d", k), {127'h0, o_p_hdr_credit_consume}, 128'h0);
    end
    i_msg_ready = 1'b1;
    #1;
    chk("hold_consume", {127'h0, o_p_hdr_credit_consume}, 128'h1);
    tick();
    i_tx_p_hdr_credit_limit = 8'h05;
    repeat (4) tick();
    chk("hold_single_valid", {127'h0, o_msg_valid}, 128'h0);
    chk("hold_single_count", {120'h0, o_msg_sent_count}, 128'h1);
    i_msg_ready = 1'b0;

    // Coalescing and ordering: NF latched first, then one fatal
    do_reset();
    i_error_check = 1'b1;
    i_error_type  = 3'b100;
    tick();
    i_error_type  = 3'b111;
    tick();
    i_error_type  = 3'b001;
    tick();
    i_error_check = 1'b0;
    i_error_type  = 3'b000;
    i_msg_ready   = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (o_p_hdr_credit_consume) begin
        if (n < 4) codes[n] = o_msg_hdr[71:64];
        n++;
      end
      @(posedge clk);
      #1;
    end
    i_msg_ready = 1'b0;
    chk("coal_num_msgs", 128'(n), 128'd2);
    chk("coal_first_code", {120'h0, codes[0]}, 128'h31);
    chk("coal_second_code", {120'h0, codes[1]}, 128'h33);
    chk("coal_count", {120'h0, o_msg_sent_count}, 128'd2);

    // Sticky status and clear/set collision
    do_reset();
    i_cfg_fatal_report_en    = 1'b0;
    i_cfg_nonfatal_report_en = 1'b0;
    strobe(3'b010);
    chk("stat_set", {127'h0, o_fatal_status}, 128'h1);
    repeat (3) tick();
    chk("stat_nomsg", {127'h0, o_msg_valid}, 128'h0);
    i_status_clr = 1'b1;
    tick();
    chk("stat_clr", {127'h0, o_fatal_status}, 128'h0);
    strobe(3'b011);
    i_status_clr = 1'b0;
    chk("stat_clr_set_wins", {127'h0, o_fatal_status}, 128'h1);

    // Continuous fatal events: one message every 2 cycles, then saturation
    do_reset();
    i_tx_p_hdr_infinite = 1'b1;
    i_msg_ready         = 1'b1;
    i_error_check       = 1'b1;
    i_error_type        = 3'b011;
    repeat (21) tick();
    chk("sat_rate_count", {120'h0, o_msg_sent_count}, 128'd10);
    repeat (600) tick();
    chk("sat_count", {120'h0, o_msg_sent_count}, 128'hFF);
    i_error_check = 1'b0;
    i_error_type  = 3'b000;
    i_msg_ready   = 1'b0;
    repeat (3) tick();
    strobe(3'b011);
    tick();
    chk("arst_pre_valid", {127'h0, o_msg_valid}, 128'h1);

    // Async reset mid-SEND
    #2 i_n_rst = 1'b0;
    #1;
    chk("arst_valid",   {127'h0, o_msg_valid}, 128'h0);
    chk("arst_hdr",     o_msg_hdr, 128'h0);
    chk("arst_status",  {126'h0, o_fatal_status, o_nonfatal_status}, 128'h0);
    chk("arst_count",   {120'h0, o_msg_sent_count}, 128'h0);
    chk("arst_consume", {127'h0, o_p_hdr_credit_consume}, 128'h0);
    #3 i_n_rst = 1'b1;
    repeat (4) tick();
    chk("arst_no_resend", {127'h0, o_msg_valid}, 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
